// File: rtl/disp_share_sched.sv
// Round-robin sharing of one 4-digit multiplexed 7-segment display between NREQ 16-bit producers.
// Optional DISP_LEADING_ZERO_BLANK_EN blanks digits above the most significant nonzero nibble.
module disp_share_sched #(
  parameter int CLKFREQ = 27000000,
  parameter int NREQ    = 3,
  parameter int HOLD_MS = 500
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [16*NREQ-1:0]   dat,
  output logic [NREQ-1:0]      grant,
  output logic [1:0]           owner,
  output logic [3:0]           digits,
  output logic [7:0]           segments
);

  localparam int TICK_DIV = (CLKFREQ / 1000 < 1) ? 1 : CLKFREQ / 1000;
  localparam int PW       = $clog2(TICK_DIV + 1);
  localparam int HW       = $clog2(HOLD_MS + 2);

  typedef enum logic [1:0] {IDLE, OWN, GAP} state_t;

  state_t          state_q;
  logic [PW-1:0]   presc_q;
  logic [HW-1:0]   hold_q;
  logic [1:0]      scan_q;
  logic [15:0]     shadow_q;
  logic [NREQ-1:0] grant_q;
  logic [1:0]      owner_q;
  logic [3:0]      digits_q;
  logic [7:0]      seg_q;

  logic            tick;
  logic [3:0]      req_w;
  logic [15:0]     dat_w [4];
  logic            win_found;
  logic [1:0]      win_idx;
  logic [1:0]      cand;
  logic [3:0]      win_oh;
  logic [3:0]      owner_oh;
  logic            others;
  logic            hold_done;
  logic [7:0]      seg_d;

  // Pad requesters out to 4 slots so every 2-bit index is in range.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_slot
      if (gi < NREQ) begin : g_real
        assign req_w[gi] = req[gi];
        assign dat_w[gi] = dat[16*gi +: 16];
      end else begin : g_none
        assign req_w[gi] = 1'b0;
        assign dat_w[gi] = 16'h0000;
      end
    end
  endgenerate

  function automatic logic [7:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 8'hC0;  4'h1: hex7 = 8'hF9;  4'h2: hex7 = 8'hA4;  4'h3: hex7 = 8'hB0;
      4'h4: hex7 = 8'h99;  4'h5: hex7 = 8'h92;  4'h6: hex7 = 8'h82;  4'h7: hex7 = 8'hF8;
      4'h8: hex7 = 8'h80;  4'h9: hex7 = 8'h90;  4'hA: hex7 = 8'h88;  4'hB: hex7 = 8'h83;
      4'hC: hex7 = 8'hC6;  4'hD: hex7 = 8'hA1;  4'hE: hex7 = 8'h86;  default: hex7 = 8'h8E;
    endcase
  endfunction

  assign tick      = (presc_q == PW'(TICK_DIV - 1));
  assign owner_oh  = 4'b0001 << owner_q;
  assign others    = |(req_w & ~owner_oh);
  assign hold_done = (hold_q == HW'(HOLD_MS));
  assign win_oh    = 4'b0001 << win_idx;

  // Walk downwards so the candidate nearest owner+1 is the one left standing.
  always_comb begin
    win_found = 1'b0;
    win_idx   = 2'd0;
    cand      = 2'd0;
    for (int k = NREQ; k >= 1; k--) begin
      cand = 2'((int'(owner_q) + k) % NREQ);
      if (req_w[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    seg_d = hex7(shadow_q[{scan_q, 2'b00} +: 4]);
    if (state_q != OWN) seg_d = 8'hFF;
`ifdef DISP_LEADING_ZERO_BLANK_EN
    if (scan_q != 2'd0 && (shadow_q >> {scan_q, 2'b00}) == 16'h0000) seg_d = 8'hFF;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      presc_q  <= '0;
      hold_q   <= '0;
      scan_q   <= 2'd0;
      shadow_q <= 16'h0000;
      grant_q  <= '0;
      owner_q  <= 2'(NREQ - 1);
      digits_q <= 4'hF;
      seg_q    <= 8'hFF;
    end else begin
      presc_q <= tick ? '0 : presc_q + 1'b1;
      if (tick) begin
        scan_q   <= scan_q + 2'd1;
        digits_q <= ~(4'b0001 << scan_q);
        seg_q    <= seg_d;
      end
      case (state_q)
        OWN: begin
          if (tick && !hold_done) hold_q <= hold_q + 1'b1;
          // Reload only at frame boundary so a frame never mixes two words.
          if (tick && scan_q == 2'd3) shadow_q <= dat_w[owner_q];
          if (!req_w[owner_q] || (hold_done && others)) begin
            state_q <= GAP;
            grant_q <= '0;
          end
        end
        IDLE, GAP: begin
          if (win_found) begin
            state_q  <= OWN;
            owner_q  <= win_idx;
            grant_q  <= win_oh[NREQ-1:0];
            hold_q   <= '0;
            shadow_q <= dat_w[win_idx];
          end else begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant    = grant_q;
  assign owner    = owner_q;
  assign digits   = digits_q;
  assign segments = seg_q;

endmodule
